// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the select codes driven onto the datapath muxes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] SRCB_REGB    = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;

  localparam logic [2:0] WB_ALUOUT = 3'b000;
  localparam logic [2:0] WB_MDR    = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_supported = 1'b1;
      default:                                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decoder. Reset presents FETCH controls with
// the PC/IR loads suppressed so nothing is captured while reset is held.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_alusrca,
  output logic [2:0] o_alusrcb,
  output logic [2:0] o_wb_sel,
  output logic [1:0] o_aluop,
  output logic [1:0] o_pcsrc,
  output logic       o_pcwrite,
  output logic       o_illegal_op
);

  state_t w_state;

  assign w_state = i_reset ? S_FETCH : i_state;

  always_comb begin
    o_iord       = 1'b0;
    o_memwrite   = 1'b0;
    o_irwrite    = 1'b0;
    o_regwrite   = 1'b0;
    o_regdst     = 1'b0;
    o_alusrca    = 1'b0;
    o_alusrcb    = SRCB_REGB;
    o_wb_sel     = WB_ALUOUT;
    o_aluop      = ALUOP_ADD;
    o_pcsrc      = PCSRC_ALU;
    o_pcwrite    = 1'b0;
    o_illegal_op = 1'b0;
    case (w_state)
      S_FETCH: begin
        o_alusrcb = SRCB_FOUR;
        o_irwrite = i_mem_ready & ~i_reset;
        o_pcwrite = i_mem_ready & ~i_reset;
      end
      S_DECODE: begin
        o_alusrcb    = SRCB_SIMM_SH;
        o_illegal_op = ~op_supported(i_opcode);
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_SIMM;
      end
      S_MEMRD: o_iord = 1'b1;
      S_MEMWB: begin
        o_wb_sel   = WB_MDR;
        o_regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      S_BEQEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_SUB;
        o_pcsrc   = PCSRC_ALUOUT;
        o_pcwrite = i_zero;
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_SIMM;
      end
      S_ORIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_ZIMM;
        o_aluop   = ALUOP_OR;
      end
      S_IMMWB: o_regwrite = 1'b1;
      S_JEX: begin
        o_pcsrc   = PCSRC_JUMP;
        o_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic; control outputs come from mc_ctrl_outdec.
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [2:0] wb_sel,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcwrite,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;

  // With waiting disabled every memory access is assumed to finish at once.
  assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_dbg   = r_state;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_ORI:       w_next = S_ORIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_IMMWB;
      S_ORIEX:   w_next = S_IMMWB;
      S_IMMWB:   w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  mc_ctrl_outdec u_outdec (
    .i_state      (r_state),
    .i_reset      (reset),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (w_mem_ready),
    .o_iord       (iord),
    .o_memwrite   (memwrite),
    .o_irwrite    (irwrite),
    .o_regwrite   (regwrite),
    .o_regdst     (regdst),
    .o_alusrca    (alusrca),
    .o_alusrcb    (alusrcb),
    .o_wb_sel     (wb_sel),
    .o_aluop      (aluop),
    .o_pcsrc      (pcsrc),
    .o_pcwrite    (pcwrite),
    .o_illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks each instruction class through
// the FSM and compares decoded controls against hand-derived values.
module tb_mc_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       iord, memwrite, irwrite, regwrite, regdst, alusrca;
  logic [2:0] alusrcb, wb_sel;
  logic [1:0] aluop, pcsrc;
  logic       pcwrite, illegal_op;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0;

  mc_main_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .wb_sel     (wb_sel),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .pcwrite    (pcwrite),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and move clear of it before touching inputs.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    tick(); tick();
    settle();
    check("rst_state", state_dbg, 0);
    check("rst_irwrite", irwrite, 0);
    check("rst_pcwrite", pcwrite, 0);
    check("rst_alusrcb", alusrcb, 3'b001);

    // R-type: 0,1,6,7,0
    reset = 1'b0; settle();
    check("fetch_irwrite", irwrite, 1);
    check("fetch_pcwrite", pcwrite, 1);
    check("fetch_alusrcb", alusrcb, 3'b001);
    check("fetch_iord", iord, 0);
    t0 = cyc;
    tick(); settle();
    check("r_dec_state", state_dbg, 1);
    check("r_dec_alusrcb", alusrcb, 3'b011);
    check("r_dec_illegal", illegal_op, 0);
    tick(); settle();
    check("r_ex_state", state_dbg, 6);
    check("r_ex_alusrcb", alusrcb, 3'b000);
    check("r_ex_aluop", aluop, 2'b10);
    check("r_ex_alusrca", alusrca, 1);
    tick(); settle();
    check("r_wb_state", state_dbg, 7);
    check("r_wb_regwrite", regwrite, 1);
    check("r_wb_regdst", regdst, 1);
    check("r_wb_wbsel", wb_sel, 3'b000);
    tick(); settle();
    check("r_back_fetch", state_dbg, 0);
    check("r_cpi", cyc - t0, 4);

    // FETCH stall when memory not ready
    mem_ready = 1'b0; settle();
    check("stall_irwrite", irwrite, 0);
    check("stall_pcwrite", pcwrite, 0);
    tick(); settle();
    check("stall_state", state_dbg, 0);
    mem_ready = 1'b1;

    // LW with 3 wait cycles in MEMRD
    opcode = 6'b100011; settle();
    t0 = cyc;
    tick(); settle();
    check("lw_dec_state", state_dbg, 1);
    tick(); settle();
    check("lw_adr_state", state_dbg, 2);
    check("lw_adr_alusrcb", alusrcb, 3'b010);
    check("lw_adr_alusrca", alusrca, 1);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lw_rd_wait_state", state_dbg, 3);
      check("lw_rd_wait_iord", iord, 1);
      tick();
    end
    mem_ready = 1'b1; settle();
    check("lw_rd_last_state", state_dbg, 3);
    tick(); settle();
    check("lw_wb_state", state_dbg, 4);
    check("lw_wb_wbsel", wb_sel, 3'b001);
    check("lw_wb_regwrite", regwrite, 1);
    check("lw_wb_regdst", regdst, 0);
    tick(); settle();
    check("lw_back_fetch", state_dbg, 0);
    check("lw_cycles", cyc - t0, 8);

    // BEQ taken then not taken
    opcode = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      t0 = cyc;
      tick(); tick(); settle();
      check("beq_state", state_dbg, 8);
      check("beq_pcwrite", pcwrite, (k == 0) ? 1 : 0);
      check("beq_pcsrc", pcsrc, 2'b01);
      check("beq_aluop", aluop, 2'b01);
      tick(); settle();
      check("beq_back_fetch", state_dbg, 0);
      check("beq_cpi", cyc - t0, 3);
    end
    zero = 1'b0;

    // ORI
    opcode = 6'b001101;
    tick(); tick(); settle();
    check("ori_state", state_dbg, 10);
    check("ori_alusrcb", alusrcb, 3'b100);
    check("ori_aluop", aluop, 2'b11);
    tick(); settle();
    check("imm_state", state_dbg, 11);
    check("imm_regwrite", regwrite, 1);
    check("imm_regdst", regdst, 0);
    tick(); settle();
    check("ori_back_fetch", state_dbg, 0);

    // ADDI
    opcode = 6'b001000;
    tick(); tick(); settle();
    check("addi_state", state_dbg, 9);
    check("addi_alusrcb", alusrcb, 3'b010);
    check("addi_aluop", aluop, 2'b00);
    tick(); tick(); settle();
    check("addi_back_fetch", state_dbg, 0);

    // J
    opcode = 6'b000010;
    tick(); tick(); settle();
    check("j_state", state_dbg, 12);
    check("j_pcsrc", pcsrc, 2'b10);
    check("j_pcwrite", pcwrite, 1);
    tick(); settle();
    check("j_back_fetch", state_dbg, 0);

    // Illegal opcode
    opcode = 6'b111111;
    tick(); settle();
    check("ill_dec_state", state_dbg, 1);
    check("ill_pulse", illegal_op, 1);
    tick(); settle();
    check("ill_back_fetch", state_dbg, 0);
    check("ill_pulse_end", illegal_op, 0);

    // SW held in MEMWR, reset on second wait cycle
    opcode = 6'b101011;
    tick(); tick(); tick();
    mem_ready = 1'b0; settle();
    check("sw_state", state_dbg, 5);
    check("sw_memwrite", memwrite, 1);
    check("sw_iord", iord, 1);
    tick(); settle();
    check("sw_wait2_state", state_dbg, 5);
    check("sw_wait2_memwrite", memwrite, 1);
    reset = 1'b1;
    tick(); settle();
    check("sw_rst_state", state_dbg, 0);
    check("sw_rst_memwrite", memwrite, 0);
    check("sw_rst_irwrite", irwrite, 0);
    reset = 1'b0; mem_ready = 1'b1; settle();
    check("post_rst_irwrite", irwrite, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
